// File: rtl/seg_pkg.sv
// Shared constants and helpers for the six-digit multiplexed seven-segment scanner.
package seg_pkg;

    localparam int NUM_DIG = 6;

    typedef logic [7:0] seg_t;
    typedef logic [2:0] dig_idx_t;

    localparam seg_t                 SEG_BLANK = 8'hFF;
    localparam logic [NUM_DIG-1:0]   SEL_NONE  = 6'h3F;
    localparam dig_idx_t             LAST_DIG  = dig_idx_t'(NUM_DIG - 1);

    // Active-low one-hot digit select for the given digit index.
    function automatic logic [NUM_DIG-1:0] sel_onehot(input dig_idx_t i);
        return ~(NUM_DIG'(1) << i);
    endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Terminal-count divider: counts 0..TC-1 while enabled and pulses wrap on the last count.
module seg_tick_div #(
    parameter int TC = 10,
    localparam int W = (TC > 1) ? $clog2(TC) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TC - 1);

    assign wrap = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_dim.sv
// Six-digit multiplexed 7-seg scanner with frame-synchronous load, guard, PWM dimming and blink.
// Define SEG_SCAN_BLINK_EN to build the per-digit blink counter and gating.
module seg_scan_dim
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 10_000,
    parameter int GUARD     = 16,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [7:0]   seg_data0,
    input  logic [7:0]   seg_data1,
    input  logic [7:0]   seg_data2,
    input  logic [7:0]   seg_data3,
    input  logic [7:0]   seg_data4,
    input  logic [7:0]   seg_data5,
    input  logic [2:0]   brightness,
    input  logic [5:0]   blink_mask,
    output logic [5:0]   seg_sel,
    output logic [7:0]   seg_data
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] GUARD_V = DW'(GUARD);

    logic [DW-1:0] dwell_cnt;
    logic          dwell_wrap;
    dig_idx_t      idx;
    logic [2:0]    pwm_cnt;
    logic          blink_phase;
    logic          frame_wrap;
    logic          dig_on;

    seg_t din     [NUM_DIG];
    seg_t pending [NUM_DIG];
    seg_t active  [NUM_DIG];
    logic pend_valid;

    seg_tick_div #(.TC(DWELL_CYC)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .cnt  (dwell_cnt),
        .wrap (dwell_wrap)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    logic [BW-1:0] unused_blink_cnt;
    logic          blink_wrap;

    seg_tick_div #(.TC(BLINK_CYC)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .cnt  (unused_blink_cnt),
        .wrap (blink_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_phase <= ~blink_phase;
        end
    end
`else
    // Blink hardware absent: mask is accepted on the port but has no effect.
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_phase       = 1'b0;
`endif

    always_comb begin
        din[0] = seg_data0;
        din[1] = seg_data1;
        din[2] = seg_data2;
        din[3] = seg_data3;
        din[4] = seg_data4;
        din[5] = seg_data5;
    end

    assign frame_wrap = dwell_wrap && (idx == LAST_DIG);

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        dig_on = 1'b0;
        if ((dwell_cnt >= GUARD_V) && (pwm_cnt <= brightness)
                && !(blink_phase && blink_mask[idx])) begin
            dig_on = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            if (dwell_wrap) begin
                idx <= (idx == LAST_DIG) ? '0 : idx + 3'd1;
            end
        end
    end

    // Double buffer: writes land in pending and only reach active at the frame boundary,
    // so a frame is never drawn with a mix of old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the six-entry buffers are plain registers, reset so the display starts blank.
            for (int i = 0; i < NUM_DIG; i++) begin
                pending[i] <= SEG_BLANK;
                active[i]  <= SEG_BLANK;
            end
            pend_valid <= 1'b0;
        end else if (frame_wrap && load) begin
            active     <= din;
            pend_valid <= 1'b0;
        end else if (frame_wrap && pend_valid) begin
            active     <= pending;
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= din;
            pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel  <= SEL_NONE;
            seg_data <= SEG_BLANK;
        end else if (dig_on) begin
            seg_sel  <= sel_onehot(idx);
            seg_data <= active[idx];
        end else begin
            seg_sel  <= SEL_NONE;
            seg_data <= SEG_BLANK;
        end
    end

endmodule
